// File: rtl/adc_serial_multich.sv
// Serial-ADC capture engine: drives cs/sclk for 1-4 ADCs sharing the bus and shifts in one
// frame per trigger (sample-rate timer or start pulse), presenting right-justified samples.
module adc_serial_multich #(
    parameter int N_CH          = 2,
    parameter int FRAME_BITS    = 16,
    parameter int DATA_BITS     = 12,
    parameter int SCLK_HALF     = 57,
    parameter int SAMPLE_PERIOD = 2268,
    parameter int QUIET_CYC     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cont_en,
    input  logic                      start,
    input  logic                      clr_ovr,
    input  logic [N_CH-1:0]           sdata,
    output logic                      cs,
    output logic                      sclk,
    output logic [N_CH*DATA_BITS-1:0] dato,
    output logic                      dato_listo,
    output logic                      busy,
    output logic                      overrun,
    output logic [1:0]                dbg_state_o
);

    localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DIV_W = $clog2(SCLK_HALF + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int QCT_W = (QUIET_CYC > 1) ? $clog2(QUIET_CYC + 1) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS);
    // The accepting IDLE cycle is itself a cs-high cycle, so QUIET lasts QUIET_CYC-1 cycles.
    localparam logic [QCT_W-1:0] QCT_LAST = QCT_W'((QUIET_CYC >= 2) ? QUIET_CYC - 2 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [QCT_W-1:0]          qct_q, qct_d;
    logic [FRAME_BITS-1:0]     sh_q [N_CH];
    logic [FRAME_BITS-1:0]     sh_d [N_CH];
    logic [N_CH*DATA_BITS-1:0] dato_q, dato_d;
    logic                      cs_q, cs_d;
    logic                      sclk_q, sclk_d;
    logic                      listo_q, listo_d;
    logic                      busy_q, busy_d;
    logic                      ovr_q, ovr_d;
    logic                      tick;
    logic                      trig;

    always_comb begin
        tmr_d = '0;
        if (cont_en) begin
            tmr_d = (tmr_q == TMR_LAST) ? '0 : tmr_q + 1'b1;
        end
    end

    assign tick = cont_en && (tmr_q == TMR_LAST);
    assign trig = cont_en ? tick : start;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        qct_d   = qct_q;
        sh_d    = sh_q;
        dato_d  = dato_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        listo_d = 1'b0;
        ovr_d   = ovr_q;

        if (clr_ovr) begin
            ovr_d = 1'b0;
        end
        if (trig && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_CONV;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    for (int c = 0; c < N_CH; c++) begin
                        sh_d[c] = '0;
                    end
                end
            end
            ST_CONV: begin
                if (bit_q == BIT_LAST) begin
                    state_d = (QUIET_CYC > 1) ? ST_QUIET : ST_IDLE;
                    cs_d    = 1'b1;
                    sclk_d  = 1'b1;
                    qct_d   = '0;
                    listo_d = 1'b1;
                    for (int c = 0; c < N_CH; c++) begin
                        dato_d[c*DATA_BITS +: DATA_BITS] = sh_q[c][DATA_BITS-1:0];
                    end
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Data is captured on the edge that raises sclk.
                    if (!sclk_q) begin
                        bit_d = bit_q + 1'b1;
                        for (int c = 0; c < N_CH; c++) begin
                            sh_d[c] = {sh_q[c][FRAME_BITS-2:0], sdata[c]};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_QUIET: begin
                if (qct_q == QCT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    qct_d = qct_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            qct_q   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                sh_q[c] <= '0;
            end
            dato_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            listo_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            qct_q   <= qct_d;
            sh_q    <= sh_d;
            dato_q  <= dato_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            listo_q <= listo_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cs          = cs_q;
    assign sclk        = sclk_q;
    assign dato        = dato_q;
    assign dato_listo  = listo_q;
    assign busy        = busy_q;
    assign overrun     = ovr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_serial_multich.sv
// Directed bench for adc_serial_multich: a two-channel instance with an ADC pin model and a
// one-channel instance whose sample period is shorter than a frame.
module tb_adc_serial_multich;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cont_en = 1'b0;
    logic        start = 1'b0;
    logic        clr_ovr = 1'b0;
    logic [1:0]  sdata = 2'b00;
    logic        cs, sclk, dato_listo, busy, overrun;
    logic [23:0] dato;
    logic [1:0]  dbg_state;

    logic        rst2 = 1'b1;
    logic        cont_en2 = 1'b0;
    logic        start2 = 1'b0;
    logic        clr_ovr2 = 1'b0;
    logic [0:0]  sdata2 = 1'b1;
    logic        cs2, sclk2, listo2, busy2, ovr2;
    logic [11:0] dato2;
    logic [1:0]  dbg_state2;

    int checks = 0;
    int errors = 0;
    int listo_cnt = 0;

    logic [15:0] word0 = 16'h0000;
    logic [15:0] word1 = 16'h0000;
    logic [15:0] sh0 = 16'h0000;
    logic [15:0] sh1 = 16'h0000;

    always #5 clk = ~clk;

    adc_serial_multich #(
        .N_CH(2), .FRAME_BITS(16), .DATA_BITS(12), .SCLK_HALF(2),
        .SAMPLE_PERIOD(100), .QUIET_CYC(4)
    ) dut (
        .clk(clk), .reset(rst), .cont_en(cont_en), .start(start), .clr_ovr(clr_ovr),
        .sdata(sdata), .cs(cs), .sclk(sclk), .dato(dato), .dato_listo(dato_listo),
        .busy(busy), .overrun(overrun), .dbg_state_o(dbg_state)
    );

    adc_serial_multich #(
        .N_CH(1), .FRAME_BITS(16), .DATA_BITS(12), .SCLK_HALF(2),
        .SAMPLE_PERIOD(60), .QUIET_CYC(4)
    ) dut2 (
        .clk(clk), .reset(rst2), .cont_en(cont_en2), .start(start2), .clr_ovr(clr_ovr2),
        .sdata(sdata2), .cs(cs2), .sclk(sclk2), .dato(dato2), .dato_listo(listo2),
        .busy(busy2), .overrun(ovr2), .dbg_state_o(dbg_state2)
    );

    // ADC pin model: latch the word when cs falls, present the next MSB after each sclk fall.
    always @(negedge cs) begin
        sh0 = word0;
        sh1 = word1;
    end

    always @(negedge sclk) begin
        if (!cs) begin
            sdata = {sh1[15], sh0[15]};
            sh0   = sh0 << 1;
            sh1   = sh1 << 1;
        end
    end

    always @(negedge clk) begin
        if (dato_listo === 1'b1) listo_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; pulses start for one cycle and follows the frame to dato_listo.
    task automatic single_shot(output int lat, output int cs_low, output int rises);
        logic prev;
        lat    = 0;
        cs_low = 0;
        rises  = 0;
        prev   = sclk;
        start  = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (!cs) cs_low++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end while (dato_listo !== 1'b1 && lat < 200);
    endtask

    // Called at the negedge of a dato_listo cycle; triggers on the first IDLE cycle after QUIET.
    task automatic back_to_back(input string tag, input logic [15:0] w, input logic [23:0] exp_dato);
        int lat;
        word0 = w;
        word1 = w;
        @(negedge clk);
        chk({tag, "_cs_q1"}, cs, 1);
        @(negedge clk);
        chk({tag, "_busy_q2"}, busy, 1);
        @(negedge clk);
        chk({tag, "_idle_cs"}, cs, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_state"}, dbg_state, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_t0_cs"}, cs, 0);
        chk({tag, "_t0_busy"}, busy, 1);
        lat = 1;
        while (dato_listo !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 66);
        chk({tag, "_dato"}, dato, exp_dato);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        int lat, cs_low, rises, base, n, first_t, last_t, bad_gap, run, min_run;
        logic prev, seen_fall;

        // Reset state
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        rst2 = 1'b0;
        chk("rst_cs", cs, 1);
        chk("rst_sclk", sclk, 1);
        chk("rst_dato", dato, 0);
        chk("rst_listo", dato_listo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_state", dbg_state, 0);
        repeat (2) @(negedge clk);

        // 1: single-shot frame
        word0 = 16'h0ABC;
        word1 = 16'h0123;
        single_shot(lat, cs_low, rises);
        chk("ss_lat", lat, 66);
        chk("ss_dato", dato, {12'h123, 12'hABC});
        chk("ss_rises", rises, 16);
        chk("ss_cs_low", cs_low, 65);
        chk("ss_busy", busy, 1);
        repeat (10) @(negedge clk);

        // 3: overrun from extra starts during CONV and QUIET
        word0 = 16'h0555;
        word1 = 16'h0AAA;
        base  = listo_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (dato_listo !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (80) @(negedge clk);
        chk("ovr_frames", listo_cnt - base, 1);
        chk("ovr_set", overrun, 1);
        chk("ovr_dato", dato, {12'hAAA, 12'h555});
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("ovr_clr", overrun, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start   = 1'b1;
        clr_ovr = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        clr_ovr = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        repeat (80) @(negedge clk);
        chk("ovr_idle_busy", busy, 0);

        // 4: reset at the seventh sclk rise
        word0 = 16'h0FED;
        word1 = 16'h0321;
        rises = 0;
        n     = 0;
        prev  = sclk;
        start = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end while (rises < 7 && n < 200);
        chk("mid_rises", rises, 7);
        base = listo_cnt;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_cs", cs, 1);
        chk("mid_sclk", sclk, 1);
        chk("mid_dato", dato, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ovr", overrun, 0);
        chk("mid_state", dbg_state, 0);
        repeat (100) @(negedge clk);
        chk("mid_no_listo", listo_cnt - base, 0);
        single_shot(lat, cs_low, rises);
        chk("mid_next_lat", lat, 66);
        chk("mid_next_dato", dato, {12'h321, 12'hFED});
        repeat (10) @(negedge clk);

        // 5: back-to-back frames with alternating patterns
        word0 = 16'h0FFF;
        word1 = 16'h0FFF;
        single_shot(lat, cs_low, rises);
        chk("b2b_first_dato", dato, 24'hFFF_FFF);
        back_to_back("b2b_zero", 16'h0000, 24'h000_000);
        back_to_back("b2b_ones", 16'h0FFF, 24'hFFF_FFF);
        repeat (10) @(negedge clk);

        // 2: continuous mode, ticks at 99,199,...,999 counted from the enabling cycle
        base      = listo_cnt;
        n         = 0;
        first_t   = -1;
        last_t    = -1;
        bad_gap   = 0;
        run       = 0;
        min_run   = 1000;
        seen_fall = 1'b0;
        prev      = cs;
        cont_en   = 1'b1;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            if (i == 1000) cont_en = 1'b0;
            if (dato_listo === 1'b1) begin
                if (first_t < 0) first_t = i;
                else if (i - last_t != 100) bad_gap++;
                last_t = i;
                n++;
            end
            if (cs) run++;
            if (!cs && prev) begin
                if (seen_fall && run < min_run) min_run = run;
                seen_fall = 1'b1;
                run = 0;
            end
            prev = cs;
        end
        chk("cont_count", n, 10);
        chk("cont_first", first_t, 165);
        chk("cont_gap", bad_gap, 0);
        chk("cont_ovr", overrun, 0);
        chk("cont_quiet", (min_run >= 4) ? 1 : 0, 1);
        chk("cont_idle", busy, 0);

        // 6: one channel, sample period shorter than frame plus quiet
        n        = 0;
        first_t  = -1;
        last_t   = -1;
        bad_gap  = 0;
        cont_en2 = 1'b1;
        for (int i = 1; i <= 450; i++) begin
            @(negedge clk);
            if (i == 400) cont_en2 = 1'b0;
            if (listo2 === 1'b1) begin
                if (first_t < 0) first_t = i;
                else if (i - last_t != 120) bad_gap++;
                last_t = i;
                n++;
            end
        end
        chk("short_count", n, 3);
        chk("short_first", first_t, 125);
        chk("short_gap", bad_gap, 0);
        chk("short_ovr", ovr2, 1);
        chk("short_dato", dato2, 12'hFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
